// File: rtl/det_pkg.sv
// Shared defaults and helpers for the detector event logger.
package det_pkg;

    localparam int DEF_POS_W = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    // One extra MSB distinguishes full from empty when the index bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/det_fwft_fifo.sv
// First-word-fall-through FIFO with reset-cleared storage so dout is never X.
module det_fwft_fifo
    import det_pkg::*;
#(
    parameter int WIDTH = DEF_POS_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [WIDTH-1:0] mem_word [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok  = pop && !empty && !clr;
    // A pop in the same cycle frees the slot the write lands in.
    assign push_ok = push && (!full || pop_ok) && !clr;
    assign dout    = mem_word[rd_ptr_reg[AW-1:0]];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg <= '0;
            end else if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                entry_reg <= din;
            end
        end

        assign mem_word[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/det_event_logger.sv
// Logs the bit position of every qualified detector hit into a small FWFT FIFO,
// with a saturating hit counter and a sticky overflow flag.
module det_event_logger
    import det_pkg::*;
#(
    parameter int POS_W = DEF_POS_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_det,
    input  logic             i_clr,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [POS_W-1:0] o_pos,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf,
    output logic             o_full
);

    logic [POS_W-1:0] pos_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;
    logic             event_hit;
    logic             pop;
    logic             fifo_empty;

    assign event_hit = i_en && i_det;
    assign pop       = o_valid && i_ready;
    assign o_valid   = !fifo_empty;
    assign o_count   = count_reg;
    assign o_ovf     = ovf_reg;

    // The pre-increment position is logged; no compensation for detector lag.
    det_fwft_fifo #(
        .WIDTH (POS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (i_clr),
        .push  (event_hit),
        .pop   (pop),
        .din   (pos_reg),
        .dout  (o_pos),
        .full  (o_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (i_clr) begin
            pos_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            if (i_en) begin
                pos_reg <= pos_reg + 1'b1;
            end
            if (event_hit && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + 1'b1;
            end
            if (event_hit && o_full && !pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

endmodule
